// File: rtl/line_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : line_addr_sequencer
//  Purpose  : Steps a 2-bit line address ({a1,a0}) for a 2-to-4 decoder.
//             Each address is held for a programmable settle time (dwell)
//             before it is flagged valid. It is then held until a downstream
//             ack, after which the next code is produced.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             en         - run enable for the sequence
//             load       - capture load_addr as start address (IDLE only)
//             load_addr  - start address
//             dwell      - settle cycles before each address is valid
//             ack        - consumer accepts the current address (VALID only)
//             a1, a0     - registered address MSB / LSB
//             addr_valid - registered: address settled and consumable
//             wrap       - registered one-cycle pulse after the last code
//  Options  : LINE_ADDR_SEQ_GRAY_EN - when defined, the sequence is Gray
//             order 00,01,11,10 instead of binary order 00,01,10,11.
//  Revision : 1.0 - initial release
// ============================================================================
module line_addr_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [1:0]         load_addr,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ack,
    output logic               a1,
    output logic               a0,
    output logic               addr_valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] c_CNT_ONE = DWELL_W'(1);

`ifdef LINE_ADDR_SEQ_GRAY_EN
    localparam logic [1:0] c_LAST_CODE = 2'b10;
`else
    localparam logic [1:0] c_LAST_CODE = 2'b11;
`endif

    state_t             r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_addr;
    logic               r_addr_valid;
    logic               r_wrap;
    logic [1:0]         w_next_addr;

    // Successor code. The Gray step 00->01->11->10->00 reduces to
    // {old LSB, inverted old MSB}, so exactly one bit toggles per step.
    always_comb begin
`ifdef LINE_ADDR_SEQ_GRAY_EN
        w_next_addr = {r_addr[0], ~r_addr[1]};
`else
        w_next_addr = r_addr + 2'b01;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= 2'b00;
            r_addr_valid <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            // wrap is a pulse: only the advancing ack edge may raise it.
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addr_valid <= 1'b0;
                    if (load) begin
                        r_addr <= load_addr;
                    end
                    if (en) begin
                        r_state <= S_DWELL;
                        r_cnt   <= dwell;
                    end
                end
                S_DWELL: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        // Counter reaching zero ends the settle window; the
                        // dwell==0 case thus still spends one cycle here.
                        r_state      <= S_VALID;
                        r_addr_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_VALID: begin
                    // en alone never withdraws a presented address; only ack
                    // leaves this state.
                    if (ack) begin
                        r_addr       <= w_next_addr;
                        r_addr_valid <= 1'b0;
                        r_wrap       <= (r_addr == c_LAST_CODE);
                        if (en) begin
                            r_state <= S_DWELL;
                            r_cnt   <= dwell;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_addr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign a1         = r_addr[1];
    assign a0         = r_addr[0];
    assign addr_valid = r_addr_valid;
    assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_line_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_addr_sequencer
//  Purpose  : Self-checking bench for line_addr_sequencer. A cycle table of
//             {inputs, expected outputs} is applied and compared, followed
//             by hand-written sequences for asynchronous reset behaviour.
//             Expected addresses are written as sequence positions P0..P3 so
//             the same table holds for the binary and Gray builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_addr_sequencer;

    localparam int DWELL_W = 4;

`ifdef LINE_ADDR_SEQ_GRAY_EN
    localparam logic [1:0] P0 = 2'b00;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b11;
    localparam logic [1:0] P3 = 2'b10;
`else
    localparam logic [1:0] P0 = 2'b00;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;
    localparam logic [1:0] P3 = 2'b11;
`endif

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               load;
    logic [1:0]         load_addr;
    logic [DWELL_W-1:0] dwell;
    logic               ack;
    logic               a1;
    logic               a0;
    logic               addr_valid;
    logic               wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               en;
        logic               load;
        logic [1:0]         la;
        logic [DWELL_W-1:0] dw;
        logic               ack;
        logic [1:0]         ea;
        logic               ev;
        logic               ew;
    } vec_t;

    vec_t vecs[$];

    line_addr_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_addr  (load_addr),
        .dwell      (dwell),
        .ack        (ack),
        .a1         (a1),
        .a0         (a0),
        .addr_valid (addr_valid),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic l, input logic [1:0] la,
                                input int dw, input logic k, input logic [1:0] ea,
                                input logic ev, input logic ew);
        vec_t v;
        v.en = e; v.load = l; v.la = la; v.dw = DWELL_W'(dw); v.ack = k;
        v.ea = ea; v.ev = ev; v.ew = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {a1a0,valid,wrap}=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; load = 1'b0; load_addr = 2'b00; dwell = '0; ack = 1'b0;

        // Latency with dwell=3, then dwell=0 laps with ack held high.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, P0, 3, 1, P0, 0, 0));
        vecs.push_back(mk(1, 0, P0, 3, 1, P0, 1, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P1, 0, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P1, 1, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P2, 0, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P2, 1, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P3, 0, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P3, 1, 0));
        vecs.push_back(mk(1, 0, P0, 0, 1, P0, 0, 1));   // wrap after last code
        vecs.push_back(mk(1, 0, P0, 0, 1, P0, 1, 0));   // wrap lasts one cycle
        // Backpressure: ack low 10 cycles, en dropped after 5.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, P0, 0, 0, P0, 1, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, P0, 0, 0, P0, 1, 0));
        vecs.push_back(mk(0, 0, P0, 0, 1, P1, 0, 0));   // one advance, to IDLE
        vecs.push_back(mk(0, 0, P0, 0, 1, P1, 0, 0));   // ack ignored in IDLE
        // Load with en in the same cycle; load during DWELL ignored.
        vecs.push_back(mk(1, 1, P2, 1, 0, P2, 0, 0));
        vecs.push_back(mk(1, 1, P0, 1, 0, P2, 0, 0));
        vecs.push_back(mk(1, 0, P0, 1, 0, P2, 1, 0));
        vecs.push_back(mk(0, 0, P0, 1, 1, P3, 0, 0));
        // Abort mid-DWELL with dwell=7.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, P0, 7, 0, P3, 0, 0));
        vecs.push_back(mk(0, 0, P0, 7, 0, P3, 0, 0));
        vecs.push_back(mk(0, 0, P0, 7, 0, P3, 0, 0));
        vecs.push_back(mk(0, 0, P0, 7, 1, P3, 0, 0));
        // Plain load in IDLE without en.
        vecs.push_back(mk(0, 1, P1, 0, 0, P1, 0, 0));
        vecs.push_back(mk(0, 0, P0, 0, 0, P1, 0, 0));

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", {a1, a0, addr_valid, wrap}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; load = vecs[i].load; load_addr = vecs[i].la;
            dwell = vecs[i].dw; ack = vecs[i].ack;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), {a1, a0, addr_valid, wrap},
                     {vecs[i].ea, vecs[i].ev, vecs[i].ew});
        end

        // Asynchronous reset mid-VALID at the third code.
        @(negedge clk);
        en = 1'b1; load = 1'b1; load_addr = P2; dwell = '0; ack = 1'b0;
        @(posedge clk);
        #1 check("seq_load_dwell", {a1, a0, addr_valid, wrap}, {P2, 2'b00});
        @(negedge clk) load = 1'b0;
        @(posedge clk);
        #1 check("seq_valid_pre_reset", {a1, a0, addr_valid, wrap}, {P2, 2'b10});
        #2 rst_n = 1'b0;
        #1 check("async_reset_no_edge", {a1, a0, addr_valid, wrap}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_release_hold", {a1, a0, addr_valid, wrap}, 4'b0000);
        @(posedge clk);
        #1 check("post_release_dwell", {a1, a0, addr_valid, wrap}, 4'b0000);
        @(posedge clk);
        #1 check("post_release_valid", {a1, a0, addr_valid, wrap}, {P0, 2'b10});
        @(negedge clk); en = 1'b0; ack = 1'b1;
        @(posedge clk);
        #1 check("post_release_advance", {a1, a0, addr_valid, wrap}, {P1, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
